data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
Memory-side responder for the core's data SRAM port: it accepts en/wen/addr/wdata requests and returns rdata one cycle later, matching synchronous-SRAM timing. Addresses decode to a local word RAM or a small MMIO block holding an LED register, a scratch register, a free-running timer and a timer compare/interrupt. It sits outside mycpu-side logic at SoC level, driving the core's data_sram_rdata and the int input bit used for the timer.

Parameters:
RAM_AW, 12, word-address bits of local RAM (RAM depth = 2^RAM_AW words of 32 bits)
MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO region

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
data_sram_en  input  1  request valid this cycle
data_sram_wen  input  4  byte write enables, bit i = byte lane i (bits 8i+7:8i); 0 = read
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  write data, lane-aligned
data_sram_rdata  output  32  read data, valid the cycle after the request
led  output  16  LED register contents
timer_int  output  1  level interrupt, timer compare match

Behaviour:
- Reset (resetn=0, async): data_sram_rdata=0, led=0, scratch=0, timer=0, timer_cmp=32'hFFFF_FFFF, timer_int=0. RAM contents are not reset.
- Decode: addr[31:16]==MMIO_HI -> MMIO; else RAM at word index addr[RAM_AW+1:2] (upper bits ignored, aliasing wraps).
- MMIO offsets (addr[15:0]): 16'hF000 LED (bits 15:0 meaningful, reads zero-extend), 16'hF004 scratch (32b R/W), 16'hE000 timer, 16'hE004 timer_cmp. Other MMIO offsets: writes dropped, reads return 0.
- Request accepted every cycle with en=1; no backpressure, no stall output.
- Read latency exactly 1: rdata registered at the rising edge ending the request cycle.
- Read-first semantics: a request with wen!=0 also updates rdata with the pre-write word of that address; a write in cycle t is visible to a read issued in cycle t+1.
- Writes: only lanes with wen[i]=1 change; other lanes keep old value. wen=4'b0000 is a pure read.
- en=0: no state change from the port; rdata holds its last value.
- Timer: increments by 1 each cycle, wraps 32'hFFFF_FFFF -> 0. Write in cycle t: timer at t+1 = byte-merged write data (no increment that cycle), then resumes counting. A read returns the timer value before that edge's increment.
- timer_int: set at the edge where timer (pre-increment value) == timer_cmp; stays 1 until any write to timer_cmp, which clears it on that edge (clear wins over simultaneous set). A timer write does not clear it.
- LED write: byte lanes 0/1 update led[7:0]/[15:8]; lanes 2/3 ignored.

Test Plan:
- Reset: drive resetn=0 mid-run with timer counting -> rdata=0, led=0, timer_int=0 immediately (async); after release, read 0xBFAFE000 at cycle 0 returns 0, later reads increase by elapsed cycles.
- RAM byte write: write 0x11223344 wen=1111 to 0x00000010, then wen=0100 wdata=0x00AA0000 same address, read -> 0x11AA3344 one cycle after read request.
- Read-first: word 0x20 holds 0xDEADBEEF; write 0x12345678 to 0x20 -> rdata next cycle 0xDEADBEEF; read next -> 0x12345678.
- Alias/wrap: with RAM_AW=12, write 0xCAFEF00D to 0x00000000, read 0x00004000 -> 0xCAFEF00D.
- Timer compare: write timer=100, timer_cmp=110 -> timer_int rises 10 cycles after counting resumes, holds; write timer_cmp=0xFFFFFFFF -> timer_int 0 next cycle.
- MMIO misc: write 0xFFFF1234 wen=1111 to 0xBFAFF000 -> led=0x1234, read -> 0x00001234; read unmapped 0xBFAF0100 -> 0; en=0 cycles -> rdata unchanged.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-SRAM-port responder: word RAM plus an MMIO block (LED, scratch, timer, timer compare).
// Every request is accepted; read data is registered one cycle later with read-first semantics.
module data_sram_responder #(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_int
);

    localparam int unsigned RamDepth = 1 << RAM_AW;

    localparam logic [15:0] OffLed     = 16'hF000;
    localparam logic [15:0] OffScratch = 16'hF004;
    localparam logic [15:0] OffTimer   = 16'hE000;
    localparam logic [15:0] OffCmp     = 16'hE004;

    logic [31:0] mem [RamDepth];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q;
    logic [31:0] scratch_q;
    logic [31:0] timer_q;
    logic [31:0] cmp_q;
    logic        int_q;

    logic              mmio_sel;
    logic [15:0]       mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_req;
    logic [31:0]       wmask;
    logic [31:0]       mmio_rdata;
    logic              led_wr, scratch_wr, timer_wr, cmp_wr, ram_wr;
    logic [31:0]       led_merged;

    logic unused_addr;
    assign unused_addr = ^data_sram_addr[1:0];

    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
    assign mmio_off = data_sram_addr[15:0];
    assign ram_idx  = data_sram_addr[RAM_AW+1:2];
    assign wr_req   = data_sram_en && (data_sram_wen != 4'b0000);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{data_sram_wen[i]}};
        end
    end

    assign ram_wr     = wr_req && !mmio_sel;
    assign led_wr     = wr_req && mmio_sel && (mmio_off == OffLed);
    assign scratch_wr = wr_req && mmio_sel && (mmio_off == OffScratch);
    assign timer_wr   = wr_req && mmio_sel && (mmio_off == OffTimer);
    assign cmp_wr     = wr_req && mmio_sel && (mmio_off == OffCmp);

    // Lanes 2/3 of an LED write have no backing bits.
    assign led_merged = ({16'h0, led_q} & ~wmask) | (data_sram_wdata & wmask);

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OffLed:     mmio_rdata = {16'h0, led_q};
            OffScratch: mmio_rdata = scratch_q;
            OffTimer:   mmio_rdata = timer_q;
            OffCmp:     mmio_rdata = cmp_q;
            default:    mmio_rdata = 32'h0;
        endcase
    end

    // Pre-write contents are sampled, giving read-first behaviour on writes.
    always_comb begin
        rdata_d = rdata_q;
        if (data_sram_en) begin
            rdata_d = mmio_sel ? mmio_rdata : mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            scratch_q <= 32'h0;
            timer_q   <= 32'h0;
            cmp_q     <= 32'hFFFF_FFFF;
            int_q     <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            if (led_wr) begin
                led_q <= led_merged[15:0];
            end
            if (scratch_wr) begin
                scratch_q <= (scratch_q & ~wmask) | (data_sram_wdata & wmask);
            end
            if (timer_wr) begin
                timer_q <= (timer_q & ~wmask) | (data_sram_wdata & wmask);
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (cmp_wr) begin
                cmp_q <= (cmp_q & ~wmask) | (data_sram_wdata & wmask);
            end
            // A compare write clears the interrupt even when a match happens on the same edge.
            if (cmp_wr) begin
                int_q <= 1'b0;
            end else if (timer_q == cmp_q) begin
                int_q <= 1'b1;
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign timer_int       = int_q;

endmodule
